symbol_sync: RTL

//   Symbol timing recovery and decimation stage placed directly after the RRC

---
 rtl/symbol_sync.sv | 101 ++++++++++
 1 files changed

// File: rtl/symbol_sync.sv
// Symbol timing recovery after the RRC matched filter: Gardner TED drives
// an accumulator that slips the symbol strobe by one sample when it saturates.
module symbol_sync #(
  parameter int SamplesPerSymbol = 4,
  parameter int AccWidth         = 32,
  parameter int Threshold        = 2**24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] in,
  output logic signed [11:0] symbol,
  output logic               symbol_valid,
  output logic               slip_early,
  output logic               slip_late,
  output logic signed [24:0] ted_error
);

  localparam int Half = SamplesPerSymbol / 2;
  localparam int CntW = $clog2(SamplesPerSymbol);
  localparam logic [CntW-1:0] CntLast = CntW'(SamplesPerSymbol - 1);
  localparam logic signed [AccWidth-1:0] ThrPos = AccWidth'(Threshold);
  localparam logic signed [AccWidth-1:0] ThrNeg = -ThrPos;

  logic        [CntW-1:0]     cnt;
  logic                       hold;
  logic signed [AccWidth-1:0] acc;
  logic signed [11:0]         y_prev;
  logic signed [11:0]         mid [Half];

  logic                       strobe;
  logic signed [11:0]         y_mid;
  logic signed [12:0]         diff;
  logic signed [24:0]         e;
  logic signed [AccWidth-1:0] acc_next;

  // Fixed half-symbol delay line; slips never retime it.
  for (genvar gi = 0; gi < Half; gi++) begin : g_mid
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mid[gi] <= '0;
        else     mid[gi] <= in;
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mid[gi] <= '0;
        else     mid[gi] <= mid[gi-1];
      end
    end
  end

  always_comb begin
    strobe   = (cnt == CntLast) && !hold;
    y_mid    = mid[Half-1];
    diff     = {y_prev[11], y_prev} - {in[11], in};
    e        = y_mid * diff;
    acc_next = acc + {{(AccWidth-25){e[24]}}, e};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      hold         <= 1'b0;
      acc          <= '0;
      y_prev       <= '0;
      symbol       <= '0;
      symbol_valid <= 1'b0;
      slip_early   <= 1'b0;
      slip_late    <= 1'b0;
      ted_error    <= '0;
    end else begin
      symbol_valid <= 1'b0;
      slip_early   <= 1'b0;
      slip_late    <= 1'b0;
      if (strobe) begin
        symbol       <= in;
        symbol_valid <= 1'b1;
        ted_error    <= e;
        y_prev       <= in;
        if (acc_next >= ThrPos) begin
          // Late: park cnt at 0 for one extra cycle.
          acc       <= '0;
          cnt       <= '0;
          hold      <= 1'b1;
          slip_late <= 1'b1;
        end else if (acc_next <= ThrNeg) begin
          acc        <= '0;
          cnt        <= CntW'(1);
          slip_early <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= '0;
        end
      end else if (hold) begin
        hold <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
